// File: rtl/exec_alu_muldiv_seq_pkg.sv
// Shared types for the execute-stage operation unit: op codes, FSM states, M-ext funct7.
// Latency: n/a (types and a pure decode helper only).
// Backpressure: n/a.
package exec_pkg;

  // Base ALU functions. PASS forwards op_b (LUI).
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_PASS = 4'd10
  } alu_fn_e;

  // M-extension functions; encoding equals the instruction funct3.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_fn_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef struct packed {
    logic    is_md;
    md_fn_e  md;
    alu_fn_e alu;
  } dec_t;

  // funct3[2] set means divide/remainder.
  function automatic logic md_is_div(input md_fn_e f);
    return f[2];
  endfunction

  // funct3 -> base function. alt is funct7[5]; it picks SUB only for R-type,
  // and SRA for both R-type and immediate shifts.
  function automatic alu_fn_e f3_alu(input logic [2:0] f3, input logic alt, input logic rtype);
    case (f3)
      3'b000:  return (rtype && alt) ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/exec_alu_muldiv_seq_if.sv
// Operand/result handshake bundle of the execute unit (master = issuer, slave = unit).
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface exec_alu_muldiv_seq_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic            is_lui;
  logic            is_mem;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_op, is_lui, is_mem, funct3, funct7, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, is_lui, is_mem, funct3, funct7, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/exec_alu_muldiv_seq_decode.sv
// Op decode: alu_op/funct3/funct7/is_lui/is_mem -> base function or M-ext function.
// Latency: combinational.
// Backpressure: none. Ports: alu_op, is_lui, is_mem, funct3, funct7 in; dec, is_multicycle out.
// EXEC_DIV_EN: when undefined, DIV/REM are not multi-cycle (the top reports them illegal).
module exec_op_decode
  import exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       is_lui,
  input  logic       is_mem,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec,
  output logic       is_multicycle
);

  always_comb begin
    dec.is_md     = 1'b0;
    dec.md        = md_fn_e'(funct3);
    dec.alu       = OP_ADD;
    is_multicycle = 1'b0;
    case (alu_op)
      // Immediate bits sit in funct7 here, so alt only matters for SRAI.
      2'b00: dec.alu = is_mem ? OP_ADD : f3_alu(funct3, funct7[5], 1'b0);
      2'b01: dec.alu = OP_SUB;
      2'b10: begin
        if (funct7 == FUNCT7_MEXT) dec.is_md = 1'b1;
        else                       dec.alu   = f3_alu(funct3, funct7[5], 1'b1);
      end
      default: dec.alu = is_lui ? OP_PASS : OP_ADD;
    endcase
`ifdef EXEC_DIV_EN
    is_multicycle = dec.is_md;
`else
    is_multicycle = dec.is_md && !md_is_div(dec.md);
`endif
  end

endmodule

// File: rtl/exec_alu_muldiv_seq.sv
// Execute-stage unit: 1-cycle registered base ALU plus sequential radix-2 MUL/DIV (RV M-ext).
// Latency: base ops T+1; MUL*/DIV* T+XLEN+2; divide-by-zero / signed overflow T+1.
// Backpressure: in_ready only when IDLE and the result register is free or draining; result held until out_ready.
// Ports: clk, rst_n (async active-low), flush (sync kill), busy out, io (slave modport of the handshake bundle).
// EXEC_DIV_EN: defined builds the divide/remainder engine; undefined makes DIV*/REM* return result 0 with illegal=1 at T+1.
module exec_alu_muldiv_seq
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  busy,
  exec_alu_muldiv_seq_if.slave  io
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int SHW   = $clog2(XLEN);

  dec_t dec;
  logic is_multicycle;

  exec_op_decode u_decode (
    .alu_op        (io.alu_op),
    .is_lui        (io.is_lui),
    .is_mem        (io.is_mem),
    .funct3        (io.funct3),
    .funct7        (io.funct7),
    .dec           (dec),
    .is_multicycle (is_multicycle)
  );

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] prod;   // MUL: {acc, multiplier}; DIV: {remainder, dividend/quotient}
  logic [XLEN-1:0]   mb_q;   // |op_b|
  logic              sa_q, sb_q;
  md_fn_e            md_q;
  logic [XLEN-1:0]   result_q;
  logic              illegal_q;
  logic              out_valid_q;

  logic accept;
  assign io.in_ready  = (state == S_IDLE) && (!out_valid_q || io.out_ready);
  assign accept       = io.in_valid && io.in_ready && !flush;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.illegal   = illegal_q;
  assign io.zero      = (result_q == '0);

  // Base ALU on the live inputs; captured into result_q on accept.
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  assign shamt = io.op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (dec.alu)
      OP_ADD:  alu_res = io.op_a + io.op_b;
      OP_SUB:  alu_res = io.op_a - io.op_b;
      OP_SLL:  alu_res = io.op_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(io.op_a) < $signed(io.op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, io.op_a < io.op_b};
      OP_XOR:  alu_res = io.op_a ^ io.op_b;
      OP_SRL:  alu_res = io.op_a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(io.op_a) >>> shamt);
      OP_OR:   alu_res = io.op_a | io.op_b;
      OP_AND:  alu_res = io.op_a & io.op_b;
      OP_PASS: alu_res = io.op_b;
      default: alu_res = '0;
    endcase
  end

  // Operand signs and magnitudes. Low-half MUL is sign-agnostic, so it runs unsigned.
  logic            signed_a, signed_b, sa, sb;
  logic [XLEN-1:0] ma, mb;
  assign signed_a = (dec.md == MD_MULH) || (dec.md == MD_MULHSU) ||
                    (dec.md == MD_DIV)  || (dec.md == MD_REM);
  assign signed_b = (dec.md == MD_MULH) || (dec.md == MD_DIV) || (dec.md == MD_REM);
  assign sa = signed_a && io.op_a[XLEN-1];
  assign sb = signed_b && io.op_b[XLEN-1];
  assign ma = sa ? -io.op_a : io.op_a;
  assign mb = sb ? -io.op_b : io.op_b;

`ifdef EXEC_DIV_EN
  // Corner cases resolved without iterating. For MIN/-1 the quotient equals op_a.
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] div_special;
  assign div_zero    = (io.op_b == '0);
  assign div_ovf     = signed_a && (io.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&io.op_b);
  assign div_special = dec.md[1] ? (div_zero ? io.op_a : '0)
                                 : (div_zero ? '1 : io.op_a);
`endif

  state_e start_state;
`ifdef EXEC_DIV_EN
  assign start_state = md_is_div(dec.md) ? S_DIV : S_MUL;
`else
  assign start_state = S_MUL;
`endif

  // One shift-add step: add multiplicand to the upper half if the LSB is set, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mb_q} : '0);
  assign mul_nxt = {mul_sum, prod[XLEN-1:1]};

`ifdef EXEC_DIV_EN
  // One restoring step: trial-subtract from the shifted remainder; borrow (MSB) means restore.
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_nxt;
  assign div_trial = {prod[2*XLEN-1:XLEN], prod[XLEN-1]} - {1'b0, mb_q};
  assign div_nxt   = div_trial[XLEN] ? {prod[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], prod[XLEN-2:0], 1'b1};
`endif

  // Sign fix-up and half/quotient/remainder selection.
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   fix_res;
  always_comb begin
    mul_full = (sa_q ^ sb_q) ? -prod : prod;
    fix_res  = (md_q == MD_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
`ifdef EXEC_DIV_EN
    if (md_is_div(md_q)) begin
      if (md_q[1]) fix_res = sa_q ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
      else         fix_res = (sa_q ^ sb_q) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      prod        <= '0;
      mb_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      md_q        <= MD_MUL;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.out_ready) out_valid_q <= 1'b0;
          if (accept) begin
            if (!dec.is_md) begin
              result_q    <= alu_res;
              illegal_q   <= 1'b0;
              out_valid_q <= 1'b1;
            end else if (!is_multicycle) begin
              result_q    <= '0;
              illegal_q   <= 1'b1;
              out_valid_q <= 1'b1;
            end
`ifdef EXEC_DIV_EN
            else if (md_is_div(dec.md) && (div_zero || div_ovf)) begin
              result_q    <= div_special;
              illegal_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end
`endif
            else begin
              prod  <= {{XLEN{1'b0}}, ma};
              mb_q  <= mb;
              sa_q  <= sa;
              sb_q  <= sb;
              md_q  <= dec.md;
              cnt   <= CNT_W'(XLEN - 1);
              busy  <= 1'b1;
              state <= start_state;
            end
          end
        end
        S_MUL: begin
          prod <= mul_nxt;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
`ifdef EXEC_DIV_EN
        S_DIV: begin
          prod <= div_nxt;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
`endif
        S_FIX: begin
          result_q    <= fix_res;
          illegal_q   <= 1'b0;
          out_valid_q <= 1'b1;
          busy        <= 1'b0;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_alu_muldiv_seq.sv
// Bench for exec_alu_muldiv_seq: vector table through a result scoreboard, then timing,
// backpressure, flush and mid-op reset sequences.
// Expected values are constants chosen per build (EXEC_DIV_EN on or off).
module tb_exec_alu_muldiv_seq;
  localparam int XLEN = 32;
`ifdef EXEC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int MC_LAT = XLEN + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic busy;

  exec_alu_muldiv_seq_if #(.XLEN(XLEN)) io ();

  exec_alu_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .io    (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  alu_op;
    logic        lui;
    logic        mem;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic lui, input logic mem,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input logic ill);
    vec_t v;
    v.alu_op = op; v.lui = lui; v.mem = mem; v.f3 = f3; v.f7 = f7;
    v.a = a; v.b = b; v.exp = exp; v.ill = ill;
    return v;
  endfunction

  // Divide-family vector: real result with the engine, 0/illegal without it.
  function automatic vec_t mkd(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
    return mk(2'b10, 1'b0, 1'b0, f3, 7'b0000001, a, b, DIV_EN ? exp : 32'h0, !DIV_EN);
  endfunction

  // Scoreboard: every completed handshake must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && io.out_valid && io.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", io.result);
      end else begin
        e = sb_q.pop_front();
        check("result", io.result, e.res);
        check("illegal", {31'b0, io.illegal}, {31'b0, e.ill});
        check("zero", {31'b0, io.zero}, {31'b0, (e.res == 32'h0)});
      end
    end
  end

  // Called between edges; returns #1 after the accepting edge with in_valid low.
  task automatic issue(input vec_t v, input bit push, output int waited);
    waited = 0;
    io.alu_op = v.alu_op; io.is_lui = v.lui; io.is_mem = v.mem;
    io.funct3 = v.f3; io.funct7 = v.f7; io.op_a = v.a; io.op_b = v.b;
    io.in_valid = 1'b1;
    while (!io.in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
    end
    if (push) sb_q.push_back('{res: v.exp, ill: v.ill});
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen.
  task automatic latency(input string name, input int req, input int start);
    int lat = start;
    while (!io.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check(name, lat, req);
  endtask

  task automatic drain();
    int w = 0;
    while ((sb_q.size() != 0 || !io.in_ready) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  task automatic quiet(input string name, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (io.out_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin : wdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w;
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    io.alu_op = 2'b00; io.is_lui = 1'b0; io.is_mem = 1'b0;
    io.funct3 = 3'b000; io.funct7 = 7'b0; io.op_a = '0; io.op_b = '0;

    // Base ops first (issued back-to-back), then M-ext.
    tbl.push_back(mk(2'b10, 0, 0, 3'b000, 7'h00, 32'd5, 32'd7, 32'd12, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b000, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFE, 0));
    tbl.push_back(mk(2'b00, 0, 1, 3'b010, 7'h00, 32'h100, 32'd8, 32'h108, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b001, 7'h00, 32'd1, 32'h21, 32'd2, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b101, 7'h00, 32'h8000_0000, 32'd4, 32'h0800_0000, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 32'hF800_0000, 0));
    tbl.push_back(mk(2'b00, 0, 0, 3'b101, 7'h20, 32'h8000_0000, 32'h404, 32'hF800_0000, 0));
    tbl.push_back(mk(2'b00, 0, 0, 3'b000, 7'h20, 32'd5, 32'd7, 32'd12, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b100, 7'h00, 32'hF0F0, 32'h0FF0, 32'hFF00, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b110, 7'h00, 32'hF000, 32'h000F, 32'hF00F, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b111, 7'h00, 32'hFF00, 32'h0F0F, 32'h0F00, 0));
    tbl.push_back(mk(2'b01, 0, 0, 3'b000, 7'h00, 32'd9, 32'd9, 32'd0, 0));
    tbl.push_back(mk(2'b11, 1, 0, 3'b000, 7'h00, 32'd123, 32'h1234_5000, 32'h1234_5000, 0));
    tbl.push_back(mk(2'b11, 0, 0, 3'b000, 7'h00, 32'h1000, 32'd4, 32'h1004, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b000, 7'h01, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b001, 7'h01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b010, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0));
    tbl.push_back(mk(2'b10, 0, 0, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'd1, 0));
    tbl.push_back(mkd(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD));
    tbl.push_back(mkd(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF));
    tbl.push_back(mkd(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF));
    tbl.push_back(mkd(3'b111, 32'd5, 32'd0, 32'd5));
    tbl.push_back(mkd(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
    tbl.push_back(mkd(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0));
    tbl.push_back(mkd(3'b101, 32'd7, 32'd2, 32'd3));
    tbl.push_back(mkd(3'b111, 32'd7, 32'd2, 32'd1));

    // Reset values.
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, io.out_valid}, 32'd0);
    check("rst_result", io.result, 32'd0);
    check("rst_zero", {31'b0, io.zero}, 32'd1);
    check("rst_illegal", {31'b0, io.illegal}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", {31'b0, io.in_ready}, 32'd1);

    // Table: base ops must be accepted every cycle with out_ready high.
    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i], 1'b1, w);
      if (i < 16) check("b2b_accept_wait", w, 0);
    end
    drain();

    // Latencies.
    issue(mk(2'b10, 0, 0, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 0), 1'b1, w);
    latency("lat_base", 1, 1);
    drain();
    issue(mk(2'b10, 0, 0, 3'b001, 7'h01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0), 1'b1, w);
    repeat (4) begin @(posedge clk); #1; end
    check("mul_in_ready", {31'b0, io.in_ready}, 32'd0);
    check("mul_busy", {31'b0, busy}, 32'd1);
    latency("lat_mulh", MC_LAT, 5);
    drain();
    issue(mkd(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF), 1'b1, w);
    latency("lat_divu_zero", 1, 1);
    drain();
    issue(mkd(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD), 1'b1, w);
    latency("lat_div", DIV_EN ? MC_LAT : 1, 1);
    drain();

    // Backpressure: result held stable for 5 cycles, single handshake on release.
    io.out_ready = 1'b0;
    issue(mk(2'b10, 0, 0, 3'b000, 7'h01, 32'd6, 32'd7, 32'd42, 0), 1'b1, w);
    latency("lat_bp_mul", MC_LAT, 1);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", {31'b0, io.out_valid}, 32'd1);
      check("bp_result", io.result, 32'd42);
      check("bp_in_ready", {31'b0, io.in_ready}, 32'd0);
    end
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {31'b0, io.out_valid}, 32'd0);
    drain();

    // Flush mid-MUL, and mid-DIV when the engine exists.
    issue(mk(2'b10, 0, 0, 3'b000, 7'h01, 32'd9, 32'd9, 32'd81, 0), 1'b0, w);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_mul_valid", {31'b0, io.out_valid}, 32'd0);
    check("flush_mul_busy", {31'b0, busy}, 32'd0);
    check("flush_mul_in_ready", {31'b0, io.in_ready}, 32'd1);
    quiet("flush_mul_quiet", 40);
    if (DIV_EN) begin
      issue(mkd(3'b100, 32'd100, 32'd3, 32'd33), 1'b0, w);
      repeat (10) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_div_in_ready", {31'b0, io.in_ready}, 32'd1);
      quiet("flush_div_quiet", 40);
    end

    // flush and in_valid together: nothing accepted.
    io.alu_op = 2'b10; io.funct3 = 3'b000; io.funct7 = 7'h00;
    io.op_a = 32'd2; io.op_b = 32'd2;
    io.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_blocks_accept", {31'b0, io.out_valid}, 32'd0);
    quiet("flush_accept_quiet", 3);

    // Asynchronous reset in the middle of a MUL.
    issue(mk(2'b10, 0, 0, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0), 1'b0, w);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_valid", {31'b0, io.out_valid}, 32'd0);
    check("midrst_zero", {31'b0, io.zero}, 32'd1);
    #2 rst_n = 1'b1;
    quiet("midrst_quiet", 40);
    issue(mk(2'b10, 0, 0, 3'b000, 7'h00, 32'd1, 32'd1, 32'd2, 0), 1'b1, w);
    latency("lat_after_reset", 1, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
